// File: rtl/hamming_tx_serializer.sv
// hamming_tx_serializer: sends 12-bit codewords as start/12 data LSB-first/stop serial frames through a one-word holding register
module hamming_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] encoded_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx_serial,
  output logic        tx_busy,
  output logic        frame_done,
  output logic [15:0] frames_sent
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state, state_n;
  logic [7:0] baud, baud_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [11:0] hold_reg, shifter, shifter_n;
  logic hold_full, load, last_baud, accept;
  assign last_baud = baud == 8'(CLKS_PER_BIT - 1);
  assign in_ready = !hold_full && rst_n;
  assign accept = in_valid && in_ready;
  assign tx_busy = state != IDLE;
  assign frame_done = state == STOP && last_baud;
  assign load = hold_full && (state == IDLE || frame_done);
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || last_baud) ? 8'd0 : baud + 8'd1;
    bit_cnt_n = bit_cnt;
    shifter_n = shifter;
    case (state)
      START: state_n = last_baud ? DATA : START;
      DATA: if (last_baud) begin
        shifter_n = shifter >> 1;
        bit_cnt_n = bit_cnt + 4'd1;
        state_n = bit_cnt == 4'd11 ? STOP : DATA;
      end
      STOP: state_n = last_baud ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = START;
      shifter_n = hold_reg;
      bit_cnt_n = 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      baud <= 8'd0;
      bit_cnt <= 4'd0;
      shifter <= 12'd0;
      hold_reg <= 12'd0;
      hold_full <= 1'b0;
      tx_serial <= 1'b1;
      frames_sent <= 16'd0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_cnt_n;
      shifter <= shifter_n;
      hold_full <= accept || (hold_full && !load);
      if (accept) hold_reg <= encoded_data;
      tx_serial <= state_n == START ? 1'b0 : state_n == DATA ? shifter_n[0] : 1'b1;
      if (frame_done) frames_sent <= frames_sent + 16'd1;
    end
  end
endmodule
